// File: rtl/uart_aes_pkg.sv
// rtl/uart_aes_pkg.sv - shared block sizes, state encodings and byte-select helper for the UART/AES framer
package uart_aes_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_BITS  = 128;

  typedef enum logic {
    RX_COLLECT = 1'b0,
    RX_HOLD    = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_t;

  // Byte idx of a block, counted from the MSB end (idx 0 = [127:120]); ~idx == 15-idx
  function automatic logic [7:0] block_byte(input logic [BLOCK_BITS-1:0] blk,
                                            input logic [3:0] idx);
    return blk[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_aes_byte_ser.sv
// rtl/uart_aes_byte_ser.sv - serialises a 128-bit result into 16 UART transmit strobes, MSB byte first
module uart_aes_byte_ser
  import uart_aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  res_valid,
  input  logic [BLOCK_BITS-1:0] res_data,
  output logic                  res_ready,
  output logic                  tx_dv,
  output logic [7:0]            tx_byte,
  input  logic                  tx_active,
  input  logic                  tx_done
);

  tx_state_t             state, state_nxt;
  logic [3:0]            idx;
  logic [BLOCK_BITS-1:0] res_q;
  logic [7:0]            byte_q;
  logic [7:0]            cur_byte;
  logic                  started;
  logic                  capture, fire, advance, finish;

  assign cur_byte  = block_byte(res_q, idx);
  assign res_ready = (state == TX_IDLE) && started;
  assign tx_dv     = fire;
  // The strobe cycle shows the fresh byte; afterwards the registered copy holds it stable
  assign tx_byte   = fire ? cur_byte : byte_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and strobe decode; i_TX_Done arriving in IDLE is ignored
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    fire      = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      TX_IDLE: begin
        if (res_valid && started) begin
          capture   = 1'b1;
          state_nxt = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!tx_active) begin
          fire      = 1'b1;
          state_nxt = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tx_done) begin
          if (idx == 4'd15) begin
            finish    = 1'b1;
            state_nxt = TX_IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = TX_SEND;
          end
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // Result capture, byte index and last-sent byte; started keeps ready low until after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      idx     <= 4'd0;
      res_q   <= '0;
      byte_q  <= 8'd0;
    end else begin
      started <= 1'b1;
      if (capture) begin
        res_q <= res_data;
        idx   <= 4'd0;
      end else if (advance) begin
        idx <= idx + 4'd1;
      end else if (finish) begin
        idx <= 4'd0;
      end
      if (fire) byte_q <= cur_byte;
    end
  end

endmodule

// File: rtl/uart_aes_framer.sv
// rtl/uart_aes_framer.sv - packs UART bytes into 128-bit AES blocks and unpacks results; optional timeout under FRAMER_TIMEOUT_EN
module uart_aes_framer #(
  parameter int BYTE_TIMEOUT = 21700
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  input  logic         i_RX_DV,
  input  logic [7:0]   i_RX_Byte,
  output logic         o_Blk_Valid,
  output logic [127:0] o_Blk_Data,
  input  logic         i_Blk_Ready,
  input  logic         i_Res_Valid,
  input  logic [127:0] i_Res_Data,
  output logic         o_Res_Ready,
  output logic         o_TX_DV,
  output logic [7:0]   o_TX_Byte,
  input  logic         i_TX_Active,
  input  logic         i_TX_Done,
  output logic         o_Overrun
);

  import uart_aes_pkg::*;

  rx_state_t             rx_state, rx_state_nxt;
  logic [3:0]            rx_count;
  logic [3:0]            wr_idx;
  logic [BLOCK_BITS-1:0] blk_data;
  logic                  overrun_q;
  logic                  blk_hs, rx_take, rx_drop, rx_timeout;

  assign blk_hs      = (rx_state == RX_HOLD) && i_Blk_Ready;
  // A byte taken during the HOLD handshake starts the next block at position 0
  assign wr_idx      = (rx_state == RX_HOLD) ? 4'd0 : rx_count;
  assign o_Blk_Valid = (rx_state == RX_HOLD);
  assign o_Blk_Data  = blk_data;
  assign o_Overrun   = overrun_q;

  // RX state register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) rx_state <= RX_COLLECT;
    else          rx_state <= rx_state_nxt;
  end

  // RX next-state: take bytes while collecting, drop them while a block waits unaccepted
  always_comb begin
    rx_state_nxt = rx_state;
    rx_take      = 1'b0;
    rx_drop      = 1'b0;
    case (rx_state)
      RX_COLLECT: begin
        if (i_RX_DV) begin
          rx_take = 1'b1;
          if (rx_count == 4'd15) rx_state_nxt = RX_HOLD;
        end
      end
      RX_HOLD: begin
        if (blk_hs) begin
          rx_state_nxt = RX_COLLECT;
          rx_take      = i_RX_DV;
        end else begin
          rx_drop = i_RX_DV;
        end
      end
      default: rx_state_nxt = RX_COLLECT;
    endcase
  end

  // Block assembly, byte count and overrun pulse
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_count  <= 4'd0;
      blk_data  <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= rx_drop;
      if (rx_take) begin
        blk_data[{~wr_idx, 3'b000} +: 8] <= i_RX_Byte;
        rx_count                         <= wr_idx + 4'd1;
      end else if (blk_hs || rx_timeout) begin
        rx_count <= 4'd0;
      end
    end
  end

`ifdef FRAMER_TIMEOUT_EN
  localparam int TW = $clog2(BYTE_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  assign rx_timeout = (rx_state == RX_COLLECT) && (rx_count != 4'd0) && !i_RX_DV &&
                      (to_cnt == TW'(BYTE_TIMEOUT - 1));

  // Idle-gap counter: runs only while a partial block is pending, cleared by every received byte
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      to_cnt <= '0;
    end else if (i_RX_DV || rx_timeout || (rx_state != RX_COLLECT) || (rx_count == 4'd0)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^BYTE_TIMEOUT;
  assign rx_timeout     = 1'b0;
`endif

  uart_aes_byte_ser u_byte_ser (
    .clk       (i_Clk),
    .rst_n     (i_Rst_L),
    .res_valid (i_Res_Valid),
    .res_data  (i_Res_Data),
    .res_ready (o_Res_Ready),
    .tx_dv     (o_TX_DV),
    .tx_byte   (o_TX_Byte),
    .tx_active (i_TX_Active),
    .tx_done   (i_TX_Done)
  );

endmodule

// File: tb/tb_uart_aes_framer.sv
// tb/tb_uart_aes_framer.sv - scoreboard bench for uart_aes_framer (expects FRAMER_TIMEOUT_EN behaviour only when that macro is defined)
module tb_uart_aes_framer;

  logic         clk = 1'b0;
  logic         i_Rst_L = 1'b0;
  logic         i_RX_DV = 1'b0;
  logic [7:0]   i_RX_Byte = 8'd0;
  logic         o_Blk_Valid;
  logic [127:0] o_Blk_Data;
  logic         i_Blk_Ready = 1'b0;
  logic         i_Res_Valid = 1'b0;
  logic [127:0] i_Res_Data = '0;
  logic         o_Res_Ready;
  logic         o_TX_DV;
  logic [7:0]   o_TX_Byte;
  logic         i_TX_Active = 1'b0;
  logic         i_TX_Done = 1'b0;
  logic         o_Overrun;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int ov_count = 0;
  int txdv_count = 0;
  int tx_timer = 0;

  logic [127:0] blk_q[$];
  logic [7:0]   tx_q[$];

  always #5 clk = ~clk;

  uart_aes_framer dut (
    .i_Clk       (clk),
    .i_Rst_L     (i_Rst_L),
    .i_RX_DV     (i_RX_DV),
    .i_RX_Byte   (i_RX_Byte),
    .o_Blk_Valid (o_Blk_Valid),
    .o_Blk_Data  (o_Blk_Data),
    .i_Blk_Ready (i_Blk_Ready),
    .i_Res_Valid (i_Res_Valid),
    .i_Res_Data  (i_Res_Data),
    .o_Res_Ready (o_Res_Ready),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Active (i_TX_Active),
    .i_TX_Done   (i_TX_Done),
    .o_Overrun   (o_Overrun)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_block(input logic [7:0] base);
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[127-8*i -: 8] = base + 8'(i);
    return b;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    @(posedge clk);
    #1;
    i_RX_DV = 1'b0;
  endtask

  task automatic send_run(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i));
  endtask

  // UART transmitter model: busy 2170 clocks per byte, then a one-cycle done strobe
  always @(posedge clk) begin
    i_TX_Done <= 1'b0;
    if (o_TX_DV && !i_TX_Active) begin
      i_TX_Active <= 1'b1;
      tx_timer    <= 2170;
    end else if (i_TX_Active) begin
      if (tx_timer == 1) begin
        i_TX_Active <= 1'b0;
        i_TX_Done   <= 1'b1;
      end
      tx_timer <= tx_timer - 1;
    end
  end

  // Output monitor: pops the scoreboards on block handshakes and transmit strobes
  always @(negedge clk) begin
    if (o_Overrun) ov_count++;
    if (i_Rst_L && o_Blk_Valid && i_Blk_Ready) begin
      hs_count++;
      checks++;
      assert (blk_q.size() != 0) else begin
        errors++;
        $error("FAIL blk_unexpected: got %h expected no block", o_Blk_Data);
      end
      if (blk_q.size() != 0) chk("blk_data", o_Blk_Data, blk_q.pop_front());
    end
    if (o_TX_DV) begin
      txdv_count++;
      checks++;
      assert (tx_q.size() != 0) else begin
        errors++;
        $error("FAIL tx_unexpected: got %h expected no strobe", o_TX_Byte);
      end
      if (tx_q.size() != 0) chk("tx_byte", 128'(o_TX_Byte), 128'(tx_q.pop_front()));
    end
  end

  initial begin
    int hs0, ov0, tx0, n;
    logic [127:0] exp_blk;

    // Reset state
    tick(3);
    chk("rst_blk_valid", 128'(o_Blk_Valid), 128'(0));
    chk("rst_blk_data", o_Blk_Data, '0);
    chk("rst_overrun", 128'(o_Overrun), 128'(0));
    chk("rst_tx_dv", 128'(o_TX_DV), 128'(0));
    chk("rst_tx_byte", 128'(o_TX_Byte), 128'(0));
    chk("rst_res_ready", 128'(o_Res_Ready), 128'(0));
    i_Rst_L = 1'b1;
    chk("res_ready_before_clk", 128'(o_Res_Ready), 128'(0));
    tick(1);
    chk("res_ready_after_clk", 128'(o_Res_Ready), 128'(1));

    // Basic block 0x00..0x0F with consumer ready
    i_Blk_Ready = 1'b1;
    hs0 = hs_count;
    blk_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
    send_run(8'h00, 16);
    chk("blk_valid_latency", 128'(o_Blk_Valid), 128'(1));
    tick(1);
    chk("blk_valid_one_cycle", 128'(o_Blk_Valid), 128'(0));
    chk("basic_hs_count", 128'(hs_count - hs0), 128'(1));

    // Held block, extra byte overruns, then accepted; next block clean
    i_Blk_Ready = 1'b0;
    ov0 = ov_count;
    hs0 = hs_count;
    blk_q.push_back(mk_block(8'h30));
    send_run(8'h30, 16);
    send_byte(8'hAA);
    tick(2);
    chk("overrun_pulses", 128'(ov_count - ov0), 128'(1));
    chk("held_data", o_Blk_Data, mk_block(8'h30));
    chk("held_valid", 128'(o_Blk_Valid), 128'(1));
    i_Blk_Ready = 1'b1;
    tick(1);
    chk("released_valid", 128'(o_Blk_Valid), 128'(0));
    blk_q.push_back(mk_block(8'h40));
    send_run(8'h40, 16);
    tick(2);
    chk("overrun_hs_count", 128'(hs_count - hs0), 128'(2));

    // Byte coincident with the HOLD handshake starts the next block
    i_Blk_Ready = 1'b0;
    ov0 = ov_count;
    hs0 = hs_count;
    blk_q.push_back(mk_block(8'h50));
    send_run(8'h50, 16);
    tick(1);
    blk_q.push_back(mk_block(8'h60));
    i_Blk_Ready = 1'b1;
    send_run(8'h60, 16);
    tick(2);
    chk("coincident_no_overrun", 128'(ov_count - ov0), 128'(0));
    chk("coincident_hs_count", 128'(hs_count - hs0), 128'(2));

    // Result serialisation
    tx0 = txdv_count;
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(i * 8'h11));
    i_Res_Data  = 128'h00112233445566778899AABBCCDDEEFF;
    i_Res_Valid = 1'b1;
    chk("res_ready_idle", 128'(o_Res_Ready), 128'(1));
    tick(1);
    i_Res_Valid = 1'b0;
    chk("first_tx_dv_latency", 128'(o_TX_DV), 128'(1));
    chk("res_ready_busy", 128'(o_Res_Ready), 128'(0));
    n = 0;
    while (((txdv_count - tx0) < 16 || !o_Res_Ready) && n < 40000) begin
      tick(1);
      n++;
    end
    chk("tx_finish_in_budget", 128'(n < 40000), 128'(1));
    tick(10);
    chk("tx_dv_count", 128'(txdv_count - tx0), 128'(16));
    chk("tx_queue_drained", 128'(tx_q.size()), 128'(0));
    chk("tx_byte_stable", 128'(o_TX_Byte), 128'(8'hFF));
    chk("res_ready_return", 128'(o_Res_Ready), 128'(1));

    // Reset mid-block discards the partial block
    hs0 = hs_count;
    send_run(8'h70, 7);
    i_Rst_L = 1'b0;
    tick(2);
    chk("midrst_blk_data", o_Blk_Data, '0);
    chk("midrst_tx_byte", 128'(o_TX_Byte), 128'(0));
    chk("midrst_res_ready", 128'(o_Res_Ready), 128'(0));
    i_Rst_L = 1'b1;
    tick(1);
    blk_q.push_back(mk_block(8'h10));
    send_run(8'h10, 16);
    tick(2);
    chk("midrst_hs_count", 128'(hs_count - hs0), 128'(1));

    // Long idle gap after a partial block
    hs0 = hs_count;
    send_run(8'h01, 5);
    tick(21710);
`ifdef FRAMER_TIMEOUT_EN
    exp_blk = mk_block(8'h20);
`else
    exp_blk = '0;
    for (int i = 0; i < 5; i++) exp_blk[127-8*i -: 8] = 8'h01 + 8'(i);
    for (int i = 5; i < 16; i++) exp_blk[127-8*i -: 8] = 8'h20 + 8'(i - 5);
`endif
    blk_q.push_back(exp_blk);
    send_run(8'h20, 16);
    tick(2);
    chk("timeout_hs_count", 128'(hs_count - hs0), 128'(1));
    chk("blk_queue_drained", 128'(blk_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
